// File: rtl/wd_frame_sched_if.sv
// Bus bundle for wd_frame_sched: serial frame input, search-core handshake and result output.
interface wd_frame_sched_if #(
   parameter int unsigned N_KEY = 8,
   parameter int unsigned N_ANS = 5
);
   logic                   in_valid;
   logic [4:0]             keyboard;
   logic [4:0]             answer;
   logic [3:0]             weight;
   logic [2:0]             match_target;
   logic                   core_start;
   logic [5*N_KEY-1:0]     core_keys;
   logic [5*N_ANS-1:0]     core_ans;
   logic [4*N_ANS-1:0]     core_wgt;
   logic [5:0]             core_tgt;
   logic                   core_done;
   logic [5*N_ANS-1:0]     core_result;
   logic [10:0]            core_value;
   logic                   out_valid;
   logic [4:0]             result;
   logic [10:0]            out_value;
   logic                   busy;
   logic                   err_flag;

   modport slave (
      input  in_valid, keyboard, answer, weight, match_target,
      input  core_done, core_result, core_value,
      output core_start, core_keys, core_ans, core_wgt, core_tgt,
      output out_valid, result, out_value, busy, err_flag
   );

   modport master (
      output in_valid, keyboard, answer, weight, match_target,
      output core_done, core_result, core_value,
      input  core_start, core_keys, core_ans, core_wgt, core_tgt,
      input  out_valid, result, out_value, busy, err_flag
   );
endinterface

// File: rtl/wd_frame_sched.sv
// Frame capture / core start / result serializer for the WD search core.
// Optional WAIT-state abort after TIMEOUT cycles is enabled by defining WD_TIMEOUT_EN.
module wd_frame_sched #(
   parameter int unsigned N_KEY   = 8,
   parameter int unsigned N_ANS   = 5,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   wd_frame_sched_if.slave  bus
);
   localparam int unsigned KEY_W   = 5 * N_KEY;
   localparam int unsigned ANS_W   = 5 * N_ANS;
   localparam int unsigned WGT_W   = 4 * N_ANS;
   localparam int unsigned MAX_KA  = (N_KEY > N_ANS) ? N_KEY : N_ANS;
   localparam int unsigned CNT_MAX = (MAX_KA > TIMEOUT + 1) ? MAX_KA : TIMEOUT + 1;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [KEY_W-1:0]   keys_q, keys_d;
   logic [ANS_W-1:0]   ans_q, ans_d;
   logic [WGT_W-1:0]   wgt_q, wgt_d;
   logic [5:0]         tgt_q, tgt_d;
   logic [ANS_W-1:0]   res_q, res_d;
   logic               start_q, start_d;
   logic               oval_q, oval_d;
   logic [4:0]         result_q, result_d;
   logic [10:0]        value_q, value_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   // State register and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         keys_q   <= '0;
         ans_q    <= '0;
         wgt_q    <= '0;
         tgt_q    <= '0;
         res_q    <= '0;
         start_q  <= 1'b0;
         oval_q   <= 1'b0;
         result_q <= '0;
         value_q  <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         keys_q   <= keys_d;
         ans_q    <= ans_d;
         wgt_q    <= wgt_d;
         tgt_q    <= tgt_d;
         res_q    <= res_d;
         start_q  <= start_d;
         oval_q   <= oval_d;
         result_q <= result_d;
         value_q  <= value_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      keys_d   = keys_q;
      ans_d    = ans_q;
      wgt_d    = wgt_q;
      tgt_d    = tgt_q;
      res_d    = res_q;
      start_d  = 1'b0;
      oval_d   = 1'b0;
      result_d = '0;
      value_d  = '0;
      busy_d   = 1'b0;
      err_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               keys_d[4:0] = bus.keyboard;
               ans_d[4:0]  = bus.answer;
               wgt_d[3:0]  = bus.weight;
               tgt_d[2:0]  = bus.match_target;
               cnt_d       = CNT_W'(1);
               state_d     = S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.in_valid) begin
               for (int unsigned i = 1; i < N_KEY; i++) begin
                  if (cnt_q == CNT_W'(i)) keys_d[5*i +: 5] = bus.keyboard;
               end
               for (int unsigned i = 1; i < N_ANS; i++) begin
                  if (cnt_q == CNT_W'(i)) begin
                     ans_d[5*i +: 5] = bus.answer;
                     wgt_d[4*i +: 4] = bus.weight;
                  end
               end
               if (cnt_q == CNT_W'(1)) tgt_d[5:3] = bus.match_target;
               if (cnt_q == CNT_W'(N_KEY - 1)) begin
                  cnt_d   = '0;
                  state_d = S_START;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               // Short frame: discard everything captured so far
               err_d   = 1'b1;
               keys_d  = '0;
               ans_d   = '0;
               wgt_d   = '0;
               tgt_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.core_done) begin
               res_d    = bus.core_result;
               result_d = bus.core_result[4:0];
               value_d  = bus.core_value;
               cnt_d    = '0;
               state_d  = S_OUT;
            end
`ifdef WD_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               res_d   = '0;
               cnt_d   = '0;
               state_d = S_OUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_OUT: begin
            if (cnt_q == CNT_W'(N_ANS - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               value_d = value_q;
               for (int unsigned i = 0; i < N_ANS; i++) begin
                  if (cnt_q + CNT_W'(1) == CNT_W'(i)) result_d = res_q[5*i +: 5];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      start_d = (state_d == S_START);
      oval_d  = (state_d == S_OUT);
      busy_d  = (state_d != S_IDLE);
   end

   assign bus.core_start = start_q;
   assign bus.core_keys  = keys_q;
   assign bus.core_ans   = ans_q;
   assign bus.core_wgt   = wgt_q;
   assign bus.core_tgt   = tgt_q;
   assign bus.out_valid  = oval_q;
   assign bus.result     = result_q;
   assign bus.out_value  = value_q;
   assign bus.busy       = busy_q;
   assign bus.err_flag   = err_q;
endmodule

// File: tb/tb_wd_frame_sched.sv
// Self-checking bench for wd_frame_sched: vector table, hand sequences and random frames.
`timescale 1ns/1ps
module tb_wd_frame_sched;
   localparam int N_KEY = 8;
   localparam int N_ANS = 5;
`ifdef WD_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1023;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wd_frame_sched_if #(.N_KEY(N_KEY), .N_ANS(N_ANS)) bus ();
   wd_frame_sched #(.N_KEY(N_KEY), .N_ANS(N_ANS), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [4:0]  keys [N_KEY];
   logic [4:0]  ans  [N_ANS];
   logic [3:0]  wgt  [N_ANS];
   logic [2:0]  ta, tb_b;
   logic [4:0]  res  [N_ANS];
   logic [10:0] val;

   typedef struct {
      int len;
      int dly;
      bit noise;
      bit use_rand;
      bit exp_start;
      bit exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5*N_KEY-1:0] pk_keys();
      logic [5*N_KEY-1:0] r;
      for (int i = 0; i < N_KEY; i++) r[5*i +: 5] = keys[i];
      return r;
   endfunction

   function automatic logic [5*N_ANS-1:0] pk_ans();
      logic [5*N_ANS-1:0] r;
      for (int i = 0; i < N_ANS; i++) r[5*i +: 5] = ans[i];
      return r;
   endfunction

   function automatic logic [4*N_ANS-1:0] pk_wgt();
      logic [4*N_ANS-1:0] r;
      for (int i = 0; i < N_ANS; i++) r[4*i +: 4] = wgt[i];
      return r;
   endfunction

   function automatic logic [5*N_ANS-1:0] pk_res();
      logic [5*N_ANS-1:0] r;
      for (int i = 0; i < N_ANS; i++) r[5*i +: 5] = res[i];
      return r;
   endfunction

   task automatic load_example();
      for (int i = 0; i < N_KEY; i++) keys[i] = 5'(i + 1);
      ans[0] = 5'd3; ans[1] = 5'd1; ans[2] = 5'd4; ans[3] = 5'd1; ans[4] = 5'd5;
      wgt[0] = 4'd9; wgt[1] = 4'd2; wgt[2] = 4'd6; wgt[3] = 4'd5; wgt[4] = 4'd3;
      ta = 3'd2; tb_b = 3'd1;
      for (int i = 0; i < N_ANS; i++) res[i] = 5'(i + 1);
      val = 11'd300;
   endtask

   task automatic load_random();
      for (int i = 0; i < N_KEY; i++) keys[i] = 5'($urandom);
      for (int i = 0; i < N_ANS; i++) begin
         ans[i] = 5'($urandom);
         wgt[i] = 4'($urandom);
         res[i] = 5'($urandom);
      end
      ta = 3'($urandom); tb_b = 3'($urandom); val = 11'($urandom);
   endtask

   // Drive len frame cycles; ends in the START cycle when a full frame was sent
   task automatic send_frame(input int len, input bit exp_start);
      logic start_seen;
      start_seen = 1'b0;
      for (int i = 0; i < len; i++) begin
         bus.in_valid     = 1'b1;
         bus.keyboard     = keys[i];
         bus.answer       = (i < N_ANS) ? ans[i] : 5'($urandom);
         bus.weight       = (i < N_ANS) ? wgt[i] : 4'($urandom);
         bus.match_target = (i == 0) ? ta : (i == 1) ? tb_b : 3'($urandom);
         bus.core_done    = 1'b0;
         step();
         if (i == 0) chk("busy_in_frame", 64'(bus.busy), 64'd1);
         if (i < len - 1) start_seen = start_seen | bus.core_start;
      end
      bus.in_valid = 1'b0;
      if (len > 1) chk("no_early_start", 64'(start_seen), 64'd0);
      if (exp_start) begin
         chk("core_start", 64'(bus.core_start), 64'd1);
         chk("core_keys",  64'(bus.core_keys), 64'(pk_keys()));
         chk("core_ans",   64'(bus.core_ans),  64'(pk_ans()));
         chk("core_wgt",   64'(bus.core_wgt),  64'(pk_wgt()));
         chk("core_tgt",   64'(bus.core_tgt),  64'({tb_b, ta}));
      end else begin
         step();
         chk("short_err",   64'(bus.err_flag),   64'd1);
         chk("short_busy",  64'(bus.busy),       64'd0);
         chk("short_start", 64'(bus.core_start), 64'd0);
         chk("short_keys",  64'(bus.core_keys),  64'd0);
         chk("short_tgt",   64'(bus.core_tgt),   64'd0);
         step();
         chk("err_pulse_len", 64'(bus.err_flag), 64'd0);
      end
   endtask

   // From the START cycle: dly idle WAIT cycles, then done, then check serialized output
   task automatic finish_frame(input int dly, input bit noise);
      logic early;
      early = 1'b0;
      bus.core_done   = noise;
      bus.core_result = 25'($urandom);
      bus.core_value  = 11'($urandom);
      bus.in_valid    = noise ? 1'($urandom) : 1'b0;
      step();
      chk("start_one_cycle", 64'(bus.core_start), 64'd0);
      early = early | bus.out_valid;
      for (int k = 0; k < dly; k++) begin
         bus.core_done = 1'b0;
         bus.in_valid  = noise ? 1'($urandom) : 1'b0;
         step();
         early = early | bus.out_valid;
      end
      chk("no_out_in_wait", 64'(early), 64'd0);
      bus.core_done   = 1'b1;
      bus.core_result = pk_res();
      bus.core_value  = val;
      bus.in_valid    = noise ? 1'($urandom) : 1'b0;
      step();
      for (int k = 0; k < N_ANS; k++) begin
         chk("out_valid", 64'(bus.out_valid), 64'd1);
         chk("result",    64'(bus.result),    64'(res[k]));
         chk("out_value", 64'(bus.out_value), 64'(val));
         bus.core_done   = noise ? 1'($urandom) : 1'b0;
         bus.core_result = 25'($urandom);
         bus.core_value  = 11'($urandom);
         bus.in_valid    = noise ? 1'($urandom) : 1'b0;
         step();
      end
      bus.in_valid  = 1'b0;
      bus.core_done = 1'b0;
      chk("out_end_valid", 64'(bus.out_valid), 64'd0);
      chk("out_end_res",   64'(bus.result),    64'd0);
      chk("out_end_val",   64'(bus.out_value), 64'd0);
      chk("out_end_busy",  64'(bus.busy),      64'd0);
      chk("out_end_err",   64'(bus.err_flag),  64'd0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_state_busy"}, 64'(bus.busy),       64'd0);
      chk({tag, "_start"},      64'(bus.core_start), 64'd0);
      chk({tag, "_oval"},       64'(bus.out_valid),  64'd0);
      chk({tag, "_result"},     64'(bus.result),     64'd0);
      chk({tag, "_value"},      64'(bus.out_value),  64'd0);
      chk({tag, "_err"},        64'(bus.err_flag),   64'd0);
      chk({tag, "_keys"},       64'(bus.core_keys),  64'd0);
      chk({tag, "_tgt"},        64'(bus.core_tgt),   64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vt [7];
      logic seen;
      vt[0] = '{len: 8, dly: 4,  noise: 0, use_rand: 0, exp_start: 1, exp_err: 0};
      vt[1] = '{len: 5, dly: 0,  noise: 0, use_rand: 0, exp_start: 0, exp_err: 1};
      vt[2] = '{len: 8, dly: 4,  noise: 1, use_rand: 0, exp_start: 1, exp_err: 0};
      vt[3] = '{len: 1, dly: 0,  noise: 0, use_rand: 1, exp_start: 0, exp_err: 1};
      vt[4] = '{len: 7, dly: 0,  noise: 0, use_rand: 1, exp_start: 0, exp_err: 1};
      vt[5] = '{len: 8, dly: 0,  noise: 0, use_rand: 1, exp_start: 1, exp_err: 0};
      vt[6] = '{len: 8, dly: 12, noise: 1, use_rand: 1, exp_start: 1, exp_err: 0};

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.keyboard = '0; bus.answer = '0; bus.weight = '0;
      bus.match_target = '0; bus.core_done = 1'b0; bus.core_result = '0; bus.core_value = '0;
      step(); step();
      chk_reset_state("reset");
      rst = 1'b0;
      step();

      // Vector table
      for (int v = 0; v < 7; v++) begin
         if (vt[v].use_rand) load_random(); else load_example();
         send_frame(vt[v].len, vt[v].exp_start);
         if (vt[v].exp_start) finish_frame(vt[v].dly, vt[v].noise);
      end

      // Reset during WAIT, late done must be ignored
      load_example();
      send_frame(N_KEY, 1'b1);
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_state("midrst");
      bus.core_done = 1'b1; bus.core_result = pk_res(); bus.core_value = val;
      step();
      bus.core_done = 1'b0;
      seen = bus.out_valid;
      for (int k = 0; k < 3; k++) begin step(); seen = seen | bus.out_valid | bus.busy; end
      chk("late_done_ignored", 64'(seen), 64'd0);
      send_frame(N_KEY, 1'b1);
      finish_frame(4, 1'b0);

`ifdef WD_TIMEOUT_EN
      // Done in the same cycle the limit is reached wins
      load_random();
      send_frame(N_KEY, 1'b1);
      finish_frame(TMO - 1, 1'b0);
      // No done at all: abort after TMO WAIT cycles
      load_random();
      send_frame(N_KEY, 1'b1);
      step();
      seen = 1'b0;
      for (int k = 0; k < TMO - 1; k++) begin step(); seen = seen | bus.err_flag | bus.out_valid; end
      chk("tmo_not_early", 64'(seen), 64'd0);
      step();
      chk("tmo_err", 64'(bus.err_flag), 64'd1);
      for (int k = 0; k < N_ANS; k++) begin
         chk("tmo_oval",  64'(bus.out_valid), 64'd1);
         chk("tmo_res",   64'(bus.result),    64'd0);
         chk("tmo_value", 64'(bus.out_value), 64'd0);
         step();
         if (k == 0) chk("tmo_err_pulse", 64'(bus.err_flag), 64'd0);
      end
      chk("tmo_end_oval", 64'(bus.out_valid), 64'd0);
      chk("tmo_end_busy", 64'(bus.busy),      64'd0);
`endif

      // Random frames against the frame-level model
      for (int r = 0; r < 30; r++) begin
         int len;
         int dly;
         bit noise;
         bit full;
         load_random();
         len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N_KEY - 1)) : N_KEY;
         dly   = int'($urandom_range(0, 12));
         noise = 1'($urandom);
         full  = (len == N_KEY);
         send_frame(len, full);
         if (full) finish_frame(dly, noise);
         if ($urandom_range(0, 2) == 0) step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
